breadboard_sweeper: RTL and testbench
=====================================

// Module: breadboard_sweeper
// PURPOSE
//  Sequential driver/capturer for the team's 4-input, 10-output combinational breadboard logic.
//  - On start, drives all 16 input vectors {w,x,y,z} in order.
//  - Waits a settle time, then captures the 10-bit response {f9..f0} into a 16x10 table.
//  - Streams the table out row by row over a valid/ready port.
//  - Replaces the free-running #-delay sweep with a synthesizable hardware test harness.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles each vector is held before capture; legal range 1..255
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   sweep request; sampled only in IDLE
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle pulse after the last row is streamed
//  vec_out    out  4   {w,x,y,z} to the breadboard logic; w is the MSB
//  resp_in    in   10  {f9..f0} from the breadboard logic; f0 is bit 0
//  rd_valid   out  1   stream row valid
//  rd_ready   in   1   stream consumer ready
//  rd_row     out  4   row index (vector value) of the presented row
//  rd_data    out  10  captured response for rd_row
//  sig_out    out  16  response signature (see CONFIGURATION)
// BEHAVIOUR
//  Reset: async assert, sync release.
//  - All outputs reset to 0, state goes to IDLE, row counter to 0.
//  - Table contents are don't-care after reset.
//  - Reset mid-sweep or mid-stream aborts immediately; done is not pulsed.
//  FSM states: IDLE, SETTLE, CAPTURE, STREAM, DONE.
//  - IDLE: if start=1, next state is SETTLE with row=0 and settle count=SETTLE_CYCLES-1.
//  - SETTLE: vec_out=row. Count decrements each cycle; when count==0, go to CAPTURE.
//    SETTLE lasts exactly SETTLE_CYCLES cycles.
//  - CAPTURE (1 cycle): vec_out=row; table[row]<=resp_in.
//    If row==15, go to STREAM with row=0. Otherwise row+1, reload count, go to SETTLE.
//  - STREAM: rd_valid=1, rd_row=row, rd_data=table[row].
//    On rd_valid&rd_ready, advance row. The transfer with row==15 goes to DONE.
//    While rd_ready=0, rd_row and rd_data are held stable.
//  - DONE (1 cycle): done=1, then IDLE.
//  Outputs outside states:
//  - vec_out=0 in IDLE, STREAM and DONE.
//  - rd_valid=0 outside STREAM.
//  Latency: sweep takes 16*(SETTLE_CYCLES+1) cycles. start high in cycle 0 gives vec_out=0 from cycle 1.
//  Start handling: start is ignored while busy; no queueing. start held high re-triggers on return to IDLE.
//  Row counter: 4 bits, wraps 15->0 only at phase change. It never wraps inside a phase.
//  rd_ready is don't-care outside STREAM; rd_ready=1 continuously streams one row per cycle.
// CONFIGURATION
//  SWEEP_SIGNATURE_EN defined:
//  - sig_out cleared to 0 when start is accepted.
//  - In each CAPTURE: sig_out <= {sig_out[14:0],sig_out[15]} ^ {6'b0,resp_in}.
//  - Final value is held until the next accepted start or reset.
//  SWEEP_SIGNATURE_EN undefined: sig_out is tied to 16'h0000; no signature register is built.
// TESTING
//  1. Reset then idle: rst_n=0 for 3 cycles, release, start=0 -> all outputs 0, busy=0, for 20 cycles.
//  2. Full sweep against the breadboard model, SETTLE_CYCLES=2, rd_ready=1:
//     - Expect 16 rows in order; row 0 data=10'h2D4, row 15 data=10'h24B.
//     - done pulses exactly once; total start-to-done time is 48+16+1 cycles.
//  3. Backpressure: rd_ready toggles 1,0,0,1,... during STREAM
//     -> no row is lost or duplicated; rd_row/rd_data are stable whenever valid&!ready.
//  4. Reset mid-sweep: assert rst_n=0 while in the SETTLE of row 7
//     -> outputs 0 immediately, no done; a new start performs a clean full sweep.
//  5. Start while busy: pulse start during CAPTURE and STREAM -> no effect; exactly one done.
//  6. SWEEP_SIGNATURE_EN build, resp_in forced to {6'b0,vec_out}:
//     - sig_out matches the bench's reference rotate-XOR model after row 15.
//     - Without the macro, sig_out=0 throughout.

Source files
------------

// File: rtl/breadboard_sweeper.sv
// Sweeps all 16 {w,x,y,z} vectors into the breadboard logic, captures each response
// and streams the table out. Optional response signature: define SWEEP_SIGNATURE_EN.
module breadboard_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_vec_out,
  input  logic [9:0]  i_resp_in,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [3:0]  o_rd_row,
  output logic [9:0]  o_rd_data,
  output logic [15:0] o_sig_out
);

  localparam logic [7:0] LP_RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCapture,
    StStream,
    StDone
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_row, w_row_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [9:0]  r_table [16];
  logic        w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Table contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_table[r_row] <= i_resp_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    o_busy      = (r_state != StIdle);
    o_done      = 1'b0;
    o_vec_out   = '0;
    o_rd_valid  = 1'b0;
    o_rd_row    = '0;
    o_rd_data   = '0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = StSettle;
          w_row_nxt   = '0;
          w_cnt_nxt   = LP_RELOAD;
        end
      end
      StSettle: begin
        o_vec_out = r_row;
        if (r_cnt == '0) begin
          w_state_nxt = StCapture;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      StCapture: begin
        o_vec_out = r_row;
        w_capture = 1'b1;
        if (r_row == 4'd15) begin
          w_state_nxt = StStream;
          w_row_nxt   = '0;
        end else begin
          w_state_nxt = StSettle;
          w_row_nxt   = r_row + 4'd1;
          w_cnt_nxt   = LP_RELOAD;
        end
      end
      StStream: begin
        o_rd_valid = 1'b1;
        o_rd_row   = r_row;
        o_rd_data  = r_table[r_row];
        if (i_rd_ready) begin
          w_row_nxt = r_row + 4'd1;
          if (r_row == 4'd15) begin
            w_state_nxt = StDone;
          end
        end
      end
      StDone: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_sig <= '0;
    end else if (w_capture) begin
      r_sig <= {r_sig[14:0], r_sig[15]} ^ {6'b0, i_resp_in};
    end
  end

  assign o_sig_out = r_sig;
`else
  assign o_sig_out = 16'h0000;
`endif

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed bench for breadboard_sweeper: reset, full sweep, backpressure, mid-sweep reset,
// start-while-busy and the response signature.
module tb_breadboard_sweeper;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_vec_out;
  logic [9:0]  i_resp_in;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [3:0]  o_rd_row;
  logic [9:0]  o_rd_data;
  logic [15:0] o_sig_out;

  int n_checks = 0;
  int n_errors = 0;
  bit ident_mode = 1'b0;

  logic [3:0] vec_log [0:48];
  logic [3:0] row_q [$];
  logic [9:0] data_q [$];
  int ndone, done_cyc, stab_err, sig_nz, busy_after;

  breadboard_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_vec_out  (o_vec_out),
    .i_resp_in  (i_resp_in),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_rd_row   (o_rd_row),
    .o_rd_data  (o_rd_data),
    .o_sig_out  (o_sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Breadboard reference responses, one per input vector.
  function automatic logic [9:0] bb_model(input logic [3:0] v);
    case (v)
      4'h0: return 10'h2D4;  4'h1: return 10'h1A3;  4'h2: return 10'h0F0;  4'h3: return 10'h3C5;
      4'h4: return 10'h155;  4'h5: return 10'h2AA;  4'h6: return 10'h0C3;  4'h7: return 10'h33C;
      4'h8: return 10'h1E7;  4'h9: return 10'h218;  4'hA: return 10'h0B6;  4'hB: return 10'h349;
      4'hC: return 10'h17D;  4'hD: return 10'h282;  4'hE: return 10'h06F;  default: return 10'h24B;
    endcase
  endfunction

  always_comb begin
    i_resp_in = ident_mode ? {6'b0, o_vec_out} : bb_model(o_vec_out);
  end

  // Runs one start-to-idle sequence from posedge+1 with DUT idle; records what it sees.
  task automatic run_sweep(input bit bp, input bit poke);
    int cyc;
    int scnt;
    bit was_stall;
    logic [3:0] h_row;
    logic [9:0] h_data;
    row_q.delete();
    data_q.delete();
    ndone = 0; done_cyc = -1; stab_err = 0; sig_nz = 0; busy_after = 0;
    for (int k = 0; k < 49; k++) vec_log[k] = 4'hx;
    h_row = '0; h_data = '0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1; scnt = 0; was_stall = 1'b0;
    while (cyc < 400 && (done_cyc < 0 || cyc <= done_cyc + 5)) begin
      i_start    = poke && (cyc == 3 || cyc == 50);
      i_rd_ready = bp ? (scnt % 3 == 0) : 1'b1;
      if (cyc <= 48) vec_log[cyc] = o_vec_out;
`ifndef SWEEP_SIGNATURE_EN
      if (o_sig_out !== 16'h0000) sig_nz++;
`endif
      if (done_cyc >= 0 && o_busy !== 1'b0) busy_after++;
      if (o_rd_valid === 1'b1) begin
        if (was_stall && (o_rd_row !== h_row || o_rd_data !== h_data)) stab_err++;
        if (i_rd_ready) begin
          row_q.push_back(o_rd_row);
          data_q.push_back(o_rd_data);
          was_stall = 1'b0;
        end else begin
          was_stall = 1'b1;
          h_row  = o_rd_row;
          h_data = o_rd_data;
        end
        scnt++;
      end
      if (o_done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    i_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_vec_out, o_rd_valid, o_rd_row, o_rd_data, o_sig_out} !== 37'h0) begin
      n_errors++;
      $display("FAIL reset_held: outputs=%h expected 0", {o_busy, o_done, o_vec_out, o_rd_valid,
               o_rd_row, o_rd_data, o_sig_out});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({o_busy, o_done, o_vec_out, o_rd_valid, o_rd_row, o_rd_data, o_sig_out} !== 37'h0) begin
        n_errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h expected 0", c, {o_busy, o_done,
                 o_vec_out, o_rd_valid, o_rd_row, o_rd_data, o_sig_out});
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] ev;
    run_sweep(1'b0, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      ev = 4'((k - 1) / 3);
      n_checks++;
      if (vec_log[k] !== ev) begin
        n_errors++;
        $display("FAIL sweep_vec cycle %0d: got %h expected %h", k, vec_log[k], ev);
      end
    end
    n_checks++;
    if (row_q.size() != 16) begin
      n_errors++;
      $display("FAIL sweep_rows: got %0d rows expected 16", row_q.size());
    end
    for (int i = 0; i < row_q.size() && i < 16; i++) begin
      n_checks++;
      if (row_q[i] !== 4'(i) || data_q[i] !== bb_model(4'(i))) begin
        n_errors++;
        $display("FAIL sweep_row %0d: got row %h data %h expected row %h data %h", i, row_q[i],
                 data_q[i], 4'(i), bb_model(4'(i)));
      end
    end
    n_checks++;
    if (ndone != 1 || done_cyc != 65) begin
      n_errors++;
      $display("FAIL sweep_done: got %0d pulses at cycle %0d expected 1 at 65", ndone, done_cyc);
    end
    n_checks++;
    if (busy_after != 0) begin
      n_errors++;
      $display("FAIL sweep_idle_after: got %0d busy cycles expected 0", busy_after);
    end
`ifndef SWEEP_SIGNATURE_EN
    n_checks++;
    if (sig_nz != 0) begin
      n_errors++;
      $display("FAIL sweep_sig_zero: got %0d nonzero cycles expected 0", sig_nz);
    end
`endif
  endtask

  task automatic test_backpressure();
    run_sweep(1'b1, 1'b0);
    n_checks++;
    if (row_q.size() != 16) begin
      n_errors++;
      $display("FAIL bp_rows: got %0d rows expected 16", row_q.size());
    end
    for (int i = 0; i < row_q.size() && i < 16; i++) begin
      n_checks++;
      if (row_q[i] !== 4'(i) || data_q[i] !== bb_model(4'(i))) begin
        n_errors++;
        $display("FAIL bp_row %0d: got row %h data %h expected row %h data %h", i, row_q[i],
                 data_q[i], 4'(i), bb_model(4'(i)));
      end
    end
    n_checks++;
    if (stab_err != 0) begin
      n_errors++;
      $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stab_err);
    end
    n_checks++;
    if (ndone != 1 || done_cyc != 95) begin
      n_errors++;
      $display("FAIL bp_done: got %0d pulses at cycle %0d expected 1 at 95", ndone, done_cyc);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int seen_done;
    seen_done = 0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (21) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) seen_done++;
    end
    n_checks++;
    if (o_vec_out !== 4'd7 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_position: got vec %h busy %b expected 7 1", o_vec_out, o_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_done, o_vec_out, o_rd_valid, o_rd_row, o_rd_data, o_sig_out} !== 37'h0) begin
      n_errors++;
      $display("FAIL mid_async_reset: outputs=%h expected 0", {o_busy, o_done, o_vec_out,
               o_rd_valid, o_rd_row, o_rd_data, o_sig_out});
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) seen_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done === 1'b1 || o_busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_errors++;
      $display("FAIL mid_no_done: got %0d done/busy cycles expected 0", seen_done);
    end
    run_sweep(1'b0, 1'b0);
    n_checks++;
    if (row_q.size() != 16 || ndone != 1 || done_cyc != 65) begin
      n_errors++;
      $display("FAIL mid_resweep: got %0d rows %0d dones at %0d expected 16 1 65", row_q.size(),
               ndone, done_cyc);
    end
    for (int i = 0; i < row_q.size() && i < 16; i++) begin
      n_checks++;
      if (data_q[i] !== bb_model(4'(i))) begin
        n_errors++;
        $display("FAIL mid_row %0d: got %h expected %h", i, data_q[i], bb_model(4'(i)));
      end
    end
  endtask

  task automatic test_start_busy();
    run_sweep(1'b0, 1'b1);
    n_checks++;
    if (ndone != 1 || done_cyc != 65) begin
      n_errors++;
      $display("FAIL busy_done: got %0d pulses at cycle %0d expected 1 at 65", ndone, done_cyc);
    end
    n_checks++;
    if (row_q.size() != 16 || busy_after != 0) begin
      n_errors++;
      $display("FAIL busy_rows: got %0d rows %0d busy-after expected 16 0", row_q.size(),
               busy_after);
    end
    n_checks++;
    if (vec_log[4] !== 4'd1 || vec_log[48] !== 4'd15) begin
      n_errors++;
      $display("FAIL busy_vec: got %h %h expected 1 f", vec_log[4], vec_log[48]);
    end
  endtask

  task automatic test_signature();
    logic [15:0] ref_sig;
    ident_mode = 1'b1;
    run_sweep(1'b0, 1'b0);
    for (int i = 0; i < row_q.size() && i < 16; i++) begin
      n_checks++;
      if (data_q[i] !== 10'(i)) begin
        n_errors++;
        $display("FAIL sig_row %0d: got %h expected %h", i, data_q[i], 10'(i));
      end
    end
`ifdef SWEEP_SIGNATURE_EN
    ref_sig = 16'h0000;
    for (int r = 0; r < 16; r++) ref_sig = {ref_sig[14:0], ref_sig[15]} ^ 16'(r);
`else
    ref_sig = 16'h0000;
    n_checks++;
    if (sig_nz != 0) begin
      n_errors++;
      $display("FAIL sig_zero_run: got %0d nonzero cycles expected 0", sig_nz);
    end
`endif
    n_checks++;
    if (o_sig_out !== ref_sig) begin
      n_errors++;
      $display("FAIL sig_final: got %h expected %h", o_sig_out, ref_sig);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_sig_out !== ref_sig) begin
      n_errors++;
      $display("FAIL sig_hold: got %h expected %h", o_sig_out, ref_sig);
    end
    ident_mode = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_rd_ready = 1'b0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_reset_mid_sweep();
    test_start_busy();
    test_signature();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
